// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD score counter slice.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } score_state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Next BCD value of a single digit; 9 rolls back to 0.
  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    bcd_inc = (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_up.sv
// One BCD digit that counts up when enabled and reports its carry-out.
module bcd_digit_up
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output bcd_digit_t digit,
  output logic       carry
);

  // Carry is only raised in the cycle this digit is actually rolling over.
  assign carry = inc && (digit == BCD_MAX);

  // Digit register: clear beats increment, so a zeroing request always wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (inc) begin
      digit <= bcd_inc(digit);
    end
  end

endmodule

// File: rtl/bcd_score_up.sv
// Two-digit BCD score counter: awards arrive over valid/ready and are
// applied one point per step_en strobe.
// Build option: define BCD_SCORE_WRAP_EN to wrap to 00 at the terminal value
// instead of saturating there.
module bcd_score_up
  import bcd_pkg::*;
#(
  parameter bcd_digit_t TERM_L = 4'd9,
  parameter bcd_digit_t TERM_H = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       step_en,
  input  logic       add_valid,
  input  logic [3:0] add_amount,
  output logic       add_ready,
  output bcd_digit_t countL,
  output bcd_digit_t countH,
  output logic       tc,
  output logic       busy
);

  score_state_t state, state_nxt;
  logic [3:0]   pending, pending_nxt;
  logic         accept;
  logic         step_apply;
  logic         inc_l;
  logic         carry_l;
  logic         carry_h_unused;
  logic         digit_clr;

  assign add_ready  = (state == IDLE) && !clear;
  assign busy       = (state == RUN);
  assign accept     = add_valid && add_ready;
  assign step_apply = (state == RUN) && step_en && !clear;
  assign tc         = (countH == TERM_H) && (countL == TERM_L);

  // The count never advances past terminal; the step there still consumes a point.
  assign inc_l = step_apply && !tc;

`ifdef BCD_SCORE_WRAP_EN
  // A step at terminal zeroes both digits so accumulation restarts from 00.
  assign digit_clr = clear || (step_apply && tc);
`else
  assign digit_clr = clear;
`endif

  bcd_digit_up u_digit_l (
    .clk   (clk),
    .reset (reset),
    .clear (digit_clr),
    .inc   (inc_l),
    .digit (countL),
    .carry (carry_l)
  );

  bcd_digit_up u_digit_h (
    .clk   (clk),
    .reset (reset),
    .clear (digit_clr),
    .inc   (carry_l),
    .digit (countH),
    .carry (carry_h_unused)
  );

  // State and pending-point registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // Next state: zero-point awards are swallowed in IDLE, RUN ends on the last point.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    if (clear) begin
      state_nxt   = IDLE;
      pending_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (add_amount != 4'd0)) begin
            pending_nxt = add_amount;
            state_nxt   = RUN;
          end
        end
        RUN: begin
          if (step_en) begin
            pending_nxt = pending - 4'd1;
            if (pending == 4'd1) begin
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          state_nxt   = IDLE;
          pending_nxt = '0;
        end
      endcase
    end
  end

endmodule
